// File: rtl/fila_enq_bridge_if.sv
// Handshake bundle between the deserializer, the enqueue bridge and the 8-entry queue.
// The master modport is the bridge side; the slave modport is the environment side.
interface fila_enq_bridge_if;
  logic       des_valid;
  logic [7:0] des_data;
  logic       des_ack;
  logic [7:0] len_in;
  logic [7:0] enq_data;
  logic       enq_out;
  logic       busy_out;
  logic [7:0] drop_count;

  modport master (
    input  des_valid, des_data, len_in,
    output des_ack, enq_data, enq_out, busy_out, drop_count
  );

  modport slave (
    output des_valid, des_data, len_in,
    input  des_ack, enq_data, enq_out, busy_out, drop_count
  );
endinterface

// File: rtl/fila_enq_bridge.sv
// Deserializer-to-queue bridge: synchronizes des_valid, captures one word per handshake and pulses enqueue once.
// Optional FILA_DROP_ON_FULL_EN: discard and count words while the queue is full instead of stalling.
module fila_enq_bridge #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clock_10khz,
  input  logic               reset,
  fila_enq_bridge_if.master  bus
);

  localparam logic [7:0] DEPTH_L = 8'(DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ENQ   = 3'd2,
    ACK   = 3'd3
`ifndef FILA_DROP_ON_FULL_EN
    , FULL = 3'd4
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   v_s;
  logic                   has_room;
  logic                   capture;
  logic [7:0]             enq_data_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock_10khz or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], bus.des_valid};
  end

  assign v_s      = sync_q[SYNC_STAGES-1];
  assign has_room = bus.len_in < DEPTH_L;

`ifdef FILA_DROP_ON_FULL_EN
  logic       drop_inc;
  logic [7:0] drop_q;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d = state_q;
    capture = 1'b0;
`ifdef FILA_DROP_ON_FULL_EN
    drop_inc = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (v_s) begin
          capture = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (has_room) begin
          state_d = ENQ;
        end else begin
`ifdef FILA_DROP_ON_FULL_EN
          state_d  = ACK;
          drop_inc = 1'b1;
`else
          state_d = FULL;
`endif
        end
      end
`ifndef FILA_DROP_ON_FULL_EN
      FULL:    if (has_room) state_d = ENQ;
`endif
      ENQ:     state_d = ACK;
      ACK:     if (!v_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_10khz or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // des_data is only sampled on the IDLE->CHECK edge, where the handshake guarantees it is stable.
  // NOTE: the data holding register is reset too, because enq_data must read 0 after reset.
  always_ff @(posedge clock_10khz or posedge reset) begin
    if (reset)        enq_data_q <= '0;
    else if (capture) enq_data_q <= bus.des_data;
  end

`ifdef FILA_DROP_ON_FULL_EN
  always_ff @(posedge clock_10khz or posedge reset) begin
    if (reset)                          drop_q <= '0;
    else if (drop_inc && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
  end
  assign bus.drop_count = drop_q;
`else
  assign bus.drop_count = 8'd0;
`endif

  // Outputs decode the state register only, so they never glitch on asynchronous inputs.
  assign bus.enq_data = enq_data_q;
  assign bus.enq_out  = (state_q == ENQ);
  assign bus.des_ack  = (state_q == ACK);
  assign bus.busy_out = (state_q != IDLE);

endmodule

// File: tb/tb_fila_enq_bridge.sv
// Self-checking bench for fila_enq_bridge: handshake timing, ordering, full handling and reset.
// Expected enqueue pulses come from a cycle-arithmetic model of the handshake, compared against a monitor queue.
`timescale 1ns/1ps
module tb_fila_enq_bridge;
  localparam int DEPTH = 8;
  localparam int S     = 2;
  localparam int LAT   = S + 1;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } pulse_t;

  logic clock_10khz = 1'b0;
  logic reset       = 1'b1;
  int   cyc         = 0;
  int   checks      = 0;
  int   errors      = 0;
  int   drops_model = 0;
  logic prev_enq    = 1'b0;

  pulse_t exp_q[$];
  pulse_t act_q[$];

  fila_enq_bridge_if bus ();

  fila_enq_bridge #(.DEPTH(DEPTH), .SYNC_STAGES(S)) dut (
    .clock_10khz (clock_10khz),
    .reset       (reset),
    .bus         (bus)
  );

  always #50 clock_10khz = ~clock_10khz;
  always @(posedge clock_10khz) cyc++;

  // Monitor: record every enqueue pulse and reject back-to-back pulses.
  always @(negedge clock_10khz) begin
    if (bus.enq_out === 1'b1) begin
      pulse_t p;
      p.cyc  = cyc;
      p.data = bus.enq_data;
      act_q.push_back(p);
      checks++;
      if (prev_enq === 1'b1) begin
        errors++;
        $display("FAIL enq_consecutive: enq_out high at cycle %0d and %0d, required single-cycle pulse", cyc - 1, cyc);
      end
    end
    prev_enq = bus.enq_out;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic compare_pulses(input string name);
    int n;
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d enq pulses, expected %0d", name, act_q.size(), exp_q.size());
    end
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (act_q[i].cyc !== exp_q[i].cyc || act_q[i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL %s_pulse%0d: got cycle %0d data %h, expected cycle %0d data %h",
                 name, i, act_q[i].cyc, act_q[i].data, exp_q[i].cyc, exp_q[i].data);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  // Wait for des_ack to reach level; returns 0 on timeout after reporting it.
  task automatic wait_ack(input logic level, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock_10khz);
      if (bus.des_ack === level) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: des_ack never reached %b, cycle %0d", name, level, cyc);
    end
  endtask

  // One full handshake. hold>0 presents full_len first and switches to low_len after hold cycles.
  task automatic send_word(input logic [7:0] d, input logic [7:0] full_len, input int hold,
                           input logic [7:0] low_len, input string name);
    int     e, t, exp_p, f;
    bit     got;
    pulse_t p;
    @(negedge clock_10khz);
    bus.des_data  = d;
    bus.len_in    = (hold > 0) ? full_len : low_len;
    bus.des_valid = 1'b1;
    e     = cyc + 1;
    t     = cyc + hold;
    exp_p = (hold > 0 && t + 1 > e + LAT) ? t + 1 : e + LAT;
    p.cyc  = exp_p;
    p.data = d;
    exp_q.push_back(p);
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock_10khz);
      if (hold > 0 && cyc >= e + LAT && cyc < exp_p) begin
        checks++;
        if (bus.des_ack !== 1'b0 || bus.busy_out !== 1'b1 || bus.enq_out !== 1'b0) begin
          errors++;
          $display("FAIL %s_stall: cycle %0d ack=%b busy=%b enq=%b, expected ack=0 busy=1 enq=0",
                   name, cyc, bus.des_ack, bus.busy_out, bus.enq_out);
        end
      end
      if (hold > 0 && cyc == t) bus.len_in = low_len;
      if (bus.des_ack === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      errors++;
      $display("FAIL %s_ack_timeout: des_ack never rose, cycle %0d", name, cyc);
      bus.des_valid = 1'b0;
      return;
    end
    checks++;
    if (cyc != exp_p + 1) begin
      errors++;
      $display("FAIL %s_ack_rise: des_ack rose at cycle %0d, expected %0d", name, cyc, exp_p + 1);
    end
    bus.des_valid = 1'b0;
    f = cyc + 1;
    wait_ack(1'b0, name, got);
    if (got) begin
      checks++;
      if (cyc != f + S) begin
        errors++;
        $display("FAIL %s_ack_fall: des_ack fell at cycle %0d, expected %0d", name, cyc, f + S);
      end
    end
  endtask

`ifdef FILA_DROP_ON_FULL_EN
  task automatic send_drop(input logic [7:0] d, input logic [7:0] len, input string name);
    int e;
    bit got;
    @(negedge clock_10khz);
    bus.des_data  = d;
    bus.len_in    = len;
    bus.des_valid = 1'b1;
    e = cyc + 1;
    wait_ack(1'b1, name, got);
    if (!got) begin
      bus.des_valid = 1'b0;
      return;
    end
    drops_model = (drops_model < 255) ? drops_model + 1 : 255;
    checks++;
    if (cyc != e + LAT || bus.drop_count !== 8'(drops_model)) begin
      errors++;
      $display("FAIL %s_drop: ack at cycle %0d count %0d, expected cycle %0d count %0d",
               name, cyc, bus.drop_count, e + LAT, drops_model);
    end
    bus.des_valid = 1'b0;
    wait_ack(1'b0, name, got);
  endtask
`endif

  task automatic check_idle_outputs(input string name);
    checks++;
    if (bus.des_ack !== 1'b0 || bus.enq_out !== 1'b0 || bus.busy_out !== 1'b0 ||
        bus.enq_data !== 8'h00 || bus.drop_count !== 8'h00) begin
      errors++;
      $display("FAIL %s: ack=%b enq=%b busy=%b data=%h drops=%0d, expected all zero",
               name, bus.des_ack, bus.enq_out, bus.busy_out, bus.enq_data, bus.drop_count);
    end
  endtask

  task automatic test_reset();
    bus.des_valid = 1'b0;
    bus.des_data  = 8'h00;
    bus.len_in    = 8'd0;
    reset         = 1'b1;
    #120;
    check_idle_outputs("reset_state");
    @(negedge clock_10khz);
    reset = 1'b0;
    repeat (3) @(negedge clock_10khz);
    check_idle_outputs("post_reset_idle");
  endtask

  task automatic test_single();
    send_word(8'hA5, 8'd0, 0, 8'd0, "single");
    compare_pulses("single");
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 5; i++) send_word(8'(i), 8'd0, 0, 8'd0, "burst");
    compare_pulses("burst");
  endtask

`ifdef FILA_DROP_ON_FULL_EN
  task automatic test_full_drop();
    for (int i = 0; i < 300; i++) send_drop(8'($urandom), 8'd8, "full_drop");
    checks++;
    if (bus.drop_count !== 8'd255) begin
      errors++;
      $display("FAIL full_drop_saturate: drop_count %0d, expected 255", bus.drop_count);
    end
    compare_pulses("full_drop");
  endtask
`else
  task automatic test_full_stall();
    send_word(8'h3C, 8'd8, 12, 8'd7, "full_stall");
    compare_pulses("full_stall");
  endtask
`endif

  task automatic test_boundary();
    send_word(8'h77, 8'd0, 0, 8'(DEPTH - 1), "bound_depth_m1");
`ifdef FILA_DROP_ON_FULL_EN
    send_drop(8'h99, 8'd9, "bound_over");
`else
    send_word(8'h99, 8'd9, 6, 8'd0, "bound_over");
`endif
    compare_pulses("boundary");
  endtask

  // des_valid high for a single sampled edge: the word must still go through.
  task automatic test_protocol_violation();
    int     e;
    bit     got;
    pulse_t p;
    @(negedge clock_10khz);
    bus.des_data  = 8'hC3;
    bus.len_in    = 8'd2;
    bus.des_valid = 1'b1;
    e = cyc + 1;
    @(negedge clock_10khz);
    bus.des_valid = 1'b0;
    p.cyc  = e + LAT;
    p.data = 8'hC3;
    exp_q.push_back(p);
    wait_ack(1'b1, "violation", got);
    if (got) begin
      checks++;
      if (cyc != e + LAT + 1) begin
        errors++;
        $display("FAIL violation_ack_rise: cycle %0d, expected %0d", cyc, e + LAT + 1);
      end
      wait_ack(1'b0, "violation", got);
      if (got) begin
        checks++;
        if (cyc != e + LAT + 2) begin
          errors++;
          $display("FAIL violation_ack_fall: cycle %0d, expected %0d", cyc, e + LAT + 2);
        end
      end
    end
    compare_pulses("violation");
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      logic [7:0] d;
      int         gap;
      d   = 8'($urandom);
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clock_10khz);
`ifdef FILA_DROP_ON_FULL_EN
      send_word(d, 8'd0, 0, 8'($urandom_range(0, DEPTH - 1)), "random");
`else
      if ($urandom_range(0, 9) < 3)
        send_word(d, 8'($urandom_range(DEPTH, 255)), $urandom_range(1, 10),
                  8'($urandom_range(0, DEPTH - 1)), "random");
      else
        send_word(d, 8'd0, 0, 8'($urandom_range(0, DEPTH - 1)), "random");
`endif
    end
    compare_pulses("random");
  endtask

  task automatic test_reset_mid_ack();
    int     e;
    bit     got;
    pulse_t p;
    @(negedge clock_10khz);
    bus.des_data  = 8'h5A;
    bus.len_in    = 8'd0;
    bus.des_valid = 1'b1;
    e = cyc + 1;
    p.cyc  = e + LAT;
    p.data = 8'h5A;
    exp_q.push_back(p);
    wait_ack(1'b1, "reset_mid_ack", got);
    #10;
    reset = 1'b1;
    #1;
    check_idle_outputs("reset_mid_ack_outputs");
    drops_model = 0;
    @(negedge clock_10khz);
    reset = 1'b0;
    e = cyc + 1;
    p.cyc  = e + LAT;
    p.data = 8'h5A;
    exp_q.push_back(p);
    wait_ack(1'b1, "reset_rearm", got);
    bus.des_valid = 1'b0;
    wait_ack(1'b0, "reset_rearm", got);
    compare_pulses("reset_mid_ack");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
`ifdef FILA_DROP_ON_FULL_EN
    test_full_drop();
`else
    test_full_stall();
`endif
    test_boundary();
    test_protocol_violation();
    test_random();
    test_reset_mid_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
